// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM bank: channel-index width,
// triangle-counter direction and duty saturation.
package pwm_pkg;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  // Channel index needs at least one bit even for a single-channel bank.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] clamp_duty(input logic [31:0] duty,
                                             input logic [31:0] limit);
    return (duty > limit) ? limit : duty;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter and boundary strobe.
// PWM_CENTER_ALIGNED_EN selects a triangle counter instead of a sawtooth.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 100,
  parameter int PERIOD   = 100
) (
  input  logic             clk,
  input  logic             reset,
  output logic             boundary_o,
  output logic [CNT_W-1:0] cnt_next_o
);

  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_s;

  // Prescaler wraps every PRESCALE clocks; tick marks its last count.
  always_comb begin
    tick_s = (psc_q == PSC_LAST);
    if (tick_s) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + PSC_W'(1);
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  dir_e dir_q, dir_d;

  // Triangle: both end values are held for one tick while direction flips.
  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    boundary_o = 1'b0;
    if (tick_s) begin
      if (dir_q == UP) begin
        if (cnt_q == CNT_LAST) begin
          dir_d = DOWN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          dir_d      = UP;
          boundary_o = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q <= UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  // Sawtooth: boundary is the tick on the last count.
  always_comb begin
    cnt_d      = cnt_q;
    boundary_o = tick_s && (cnt_q == CNT_LAST);
    if (tick_s) begin
      if (boundary_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q <= '0;
      cnt_q <= '0;
    end else begin
      psc_q <= psc_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with shadowed duty registers loaded at period
// boundaries. Build option: PWM_CENTER_ALIGNED_EN (center-aligned timebase).
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 100,
  parameter int PERIOD   = 100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [chan_w(CHANNELS)-1:0]   wr_chan,
  input  logic [CNT_W-1:0]              wr_duty,
  input  logic [CHANNELS-1:0]           gate,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic                          period_start
);

  localparam int CH_W   = chan_w(CHANNELS);
  // One extra bit so a duty of exactly PERIOD = 2^CNT_W stays representable.
  localparam int DUTY_W = CNT_W + 1;

  logic                boundary_s;
  logic [CNT_W-1:0]    cnt_next_s;
  logic                wr_fire_s;
  logic [DUTY_W-1:0]   duty_sat_s;
  logic [DUTY_W-1:0]   shadow_q [CHANNELS];
  logic [DUTY_W-1:0]   shadow_d [CHANNELS];
  logic [DUTY_W-1:0]   active_q [CHANNELS];
  logic [DUTY_W-1:0]   active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q;

  pwm_timebase #(
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE),
    .PERIOD   (PERIOD)
  ) u_timebase (
    .clk        (clk),
    .reset      (reset),
    .boundary_o (boundary_s),
    .cnt_next_o (cnt_next_s)
  );

  assign wr_ready   = ~boundary_s;
  assign wr_fire_s  = wr_valid && wr_ready;
  assign duty_sat_s = DUTY_W'(clamp_duty(32'(wr_duty), 32'(PERIOD)));

  // Outputs compare against next-state cnt/duty so they line up with period_start.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_fire_s && (wr_chan == CH_W'(i))) begin
        shadow_d[i] = duty_sat_s;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
      if (boundary_s) begin
        active_d[i] = shadow_q[i];
      end else begin
        active_d[i] = active_q[i];
      end
      pwm_d[i] = gate[i] && ({1'b0, cnt_next_s} < active_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      pwm_q          <= pwm_d;
      period_start_q <= boundary_s;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule
